btn_press_encoder: RTL and testbench

- Front end for the three game buttons. It synchronises and debounces the raw btn inputs and encodes each press into a 2-bit code.
- Each code is delivered as one valid/ready transaction, so the game FSM sees exactly one event per physical press.
- Sits between the board pins and the game controller's input-receive state. The code values match the game's sequence numbering.

---
 rtl/btn_press_encoder.sv | 170 +++++++++++++++++
 tb/tb_btn_press_encoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_press_encoder.sv
`default_nettype none
// ============================================================================
// Module   : btn_press_encoder
// Brief    : Synchronises and debounces three raw game buttons, encodes each
//            accepted press into a 2-bit code and hands it to the game
//            controller as a single valid/ready transaction per press.
// Revision : 1.0 - initial release
// ============================================================================
module btn_press_encoder #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] btn,
    input  logic       press_ready,
    output logic       press_valid,
    output logic [1:0] press_code,
    output logic       multi_err,
    output logic       busy
);

    // FSM state encoding
    localparam logic [2:0] S_IDLE             = 3'd0;
    localparam logic [2:0] S_DEBOUNCE         = 3'd1;
    localparam logic [2:0] S_WAIT_ACCEPT      = 3'd2;
    localparam logic [2:0] S_WAIT_RELEASE     = 3'd3;
    localparam logic [2:0] S_RELEASE_DEBOUNCE = 3'd4;

    // Terminal count: the compare value reached after DEBOUNCE_CYCLES stable cycles
    localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    // Inversion mask so that the rest of the design always sees 1 = pressed
    localparam logic [2:0]       c_BTN_INVERT = {3{BTN_ACTIVE_LOW}};

    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_state;
    logic [2:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press_valid;
    logic [1:0]       r_press_code;
    logic             r_multi_err;
    logic             r_busy;

    logic [2:0]       w_btn_norm;
    logic [2:0]       w_s;
    logic             w_any;
    logic             w_one_hot;
    logic             w_cnt_done;
    logic [1:0]       w_cand_code;

    assign w_btn_norm = btn ^ c_BTN_INVERT;
    assign w_s        = r_sync2;
    assign w_any      = |w_s;
    assign w_one_hot  = (w_s == 3'b001) || (w_s == 3'b010) || (w_s == 3'b100);
    assign w_cnt_done = (r_cnt == c_CNT_LAST);

    // Map the latched one-hot candidate onto the game's sequence numbering
    always_comb begin
        w_cand_code = 2'd0;
        case (r_cand)
            3'b001:  w_cand_code = 2'd0;
            3'b010:  w_cand_code = 2'd1;
            3'b100:  w_cand_code = 2'd2;
            default: w_cand_code = 2'd0;
        endcase
    end

    // Two-flop synchroniser per button bit for the asynchronous pin inputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= w_btn_norm;
            r_sync2 <= r_sync1;
        end
    end

    // Press/release debounce FSM with registered handshake and status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cand        <= 3'b000;
            r_cnt         <= c_CNT_ZERO;
            r_press_valid <= 1'b0;
            r_press_code  <= 2'd0;
            r_multi_err   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            // multi_err is a single-cycle pulse unless re-raised below
            r_multi_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_one_hot) begin
                        r_cand  <= w_s;
                        r_cnt   <= c_CNT_ZERO;
                        r_state <= S_DEBOUNCE;
                        r_busy  <= 1'b1;
                    end else if (w_any) begin
                        // Chord from idle: flag it and wait for all buttons up
                        r_multi_err <= 1'b1;
                        r_state     <= S_WAIT_RELEASE;
                        r_busy      <= 1'b1;
                    end
                end

                S_DEBOUNCE: begin
                    if (w_s != r_cand) begin
                        // Bounce, early release or a second button: start over
                        r_cnt   <= c_CNT_ZERO;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_cnt_done) begin
                        r_press_valid <= 1'b1;
                        r_press_code  <= w_cand_code;
                        r_state       <= S_WAIT_ACCEPT;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                S_WAIT_ACCEPT: begin
                    // Code stays put regardless of the buttons until consumed
                    if (r_press_valid && press_ready) begin
                        r_press_valid <= 1'b0;
                        r_state       <= S_WAIT_RELEASE;
                    end
                end

                S_WAIT_RELEASE: begin
                    if (!w_any) begin
                        r_cnt   <= c_CNT_ZERO;
                        r_state <= S_RELEASE_DEBOUNCE;
                    end
                end

                S_RELEASE_DEBOUNCE: begin
                    if (w_any) begin
                        // Any activity while releasing restarts the release wait
                        r_state <= S_WAIT_RELEASE;
                    end else if (w_cnt_done) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                default: begin
                    r_state       <= S_IDLE;
                    r_cnt         <= c_CNT_ZERO;
                    r_press_valid <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign press_valid = r_press_valid;
    assign press_code  = r_press_code;
    assign multi_err   = r_multi_err;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_btn_press_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_press_encoder
// Brief    : Self-checking bench for btn_press_encoder: table-driven press
//            vectors with a code scoreboard, plus hand-written sequences for
//            latency, backpressure, bounce, release glitch and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_press_encoder;

    localparam int c_DEB = 4;

    logic       clock;
    logic       reset;
    logic [2:0] btn;
    logic       press_ready;
    logic       press_valid;
    logic [1:0] press_code;
    logic       multi_err;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_xfer   = 0;
    int n_vhigh  = 0;
    int n_merr   = 0;

    logic [1:0] exp_q[$];

    typedef struct {
        logic [2:0] btn;
        int         hold;
        int         n_codes;
        logic [1:0] code;
        int         n_multi;
    } vec_t;

    vec_t vecs[7];

    btn_press_encoder #(
        .DEBOUNCE_CYCLES(c_DEB),
        .CNT_W          (8),
        .BTN_ACTIVE_LOW (1'b0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn        (btn),
        .press_ready(press_ready),
        .press_valid(press_valid),
        .press_code (press_code),
        .multi_err  (multi_err),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard side: every accepted transfer must match the next expected code
    always @(negedge clock) begin
        if (!reset) begin
            if (press_valid) n_vhigh++;
            if (multi_err) n_merr++;
            if (press_valid && press_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) check("unexpected_xfer", 1, 0);
                else check("xfer_code", int'(press_code), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int x0, v0, m0, bad;

        vecs[0] = '{btn: 3'b001, hold: 20, n_codes: 1, code: 2'd0, n_multi: 0};
        vecs[1] = '{btn: 3'b001, hold: 12, n_codes: 1, code: 2'd0, n_multi: 0};
        vecs[2] = '{btn: 3'b010, hold: 12, n_codes: 1, code: 2'd1, n_multi: 0};
        vecs[3] = '{btn: 3'b100, hold: 12, n_codes: 1, code: 2'd2, n_multi: 0};
        vecs[4] = '{btn: 3'b011, hold: 12, n_codes: 0, code: 2'd0, n_multi: 1};
        vecs[5] = '{btn: 3'b001, hold: 3,  n_codes: 0, code: 2'd0, n_multi: 0};
        vecs[6] = '{btn: 3'b111, hold: 10, n_codes: 0, code: 2'd0, n_multi: 1};

        reset       = 1'b1;
        btn         = 3'b000;
        press_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", int'(press_valid), 0);
        check("rst_code",  int'(press_code),  0);
        check("rst_multi", int'(multi_err),   0);
        check("rst_busy",  int'(busy),        0);
        reset = 1'b0;
        repeat (2) tick();

        // Table-driven presses with press_ready held high
        press_ready = 1'b1;
        foreach (vecs[i]) begin
            x0 = n_xfer; v0 = n_vhigh; m0 = n_merr;
            if (vecs[i].n_codes != 0) exp_q.push_back(vecs[i].code);
            btn = vecs[i].btn;
            repeat (vecs[i].hold) tick();
            btn = 3'b000;
            repeat (12) tick();
            check($sformatf("vec%0d_xfers", i), n_xfer - x0, vecs[i].n_codes);
            check($sformatf("vec%0d_valid_cycles", i), n_vhigh - v0, vecs[i].n_codes);
            check($sformatf("vec%0d_multi", i), n_merr - m0, vecs[i].n_multi);
            check($sformatf("vec%0d_idle", i), int'(busy), 0);
            check($sformatf("vec%0d_pending", i), exp_q.size(), 0);
            exp_q.delete();
        end

        // Latency and backpressure on btn[2]
        press_ready = 1'b0;
        btn = 3'b100;
        repeat (c_DEB + 2) tick();
        check("lat_valid_early", int'(press_valid), 0);
        tick();
        check("lat_valid_edge7", int'(press_valid), 1);
        check("lat_code", int'(press_code), 2);
        check("lat_busy", int'(busy), 1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) btn = 3'b000;
            tick();
            if (!(press_valid && press_code == 2'd2)) bad++;
        end
        check("bp_hold_stable", bad, 0);
        exp_q.push_back(2'd2);
        x0 = n_xfer;
        press_ready = 1'b1;
        tick();
        press_ready = 1'b0;
        check("bp_valid_drop", int'(press_valid), 0);
        check("bp_one_xfer", n_xfer - x0, 1);
        repeat (4) tick();
        check("bp_busy_before", int'(busy), 1);
        tick();
        check("bp_busy_cleared", int'(busy), 0);

        // Bounce on btn[1]: 1,1,0,1,0 then a stable run
        press_ready = 1'b1;
        x0 = n_xfer;
        exp_q.push_back(2'd1);
        btn = 3'b010; tick();
        btn = 3'b010; tick();
        btn = 3'b000; tick();
        btn = 3'b010; tick();
        btn = 3'b000; tick();
        btn = 3'b010;
        repeat (c_DEB + 2) tick();
        check("bounce_no_early_valid", n_xfer - x0, 0);
        check("bounce_valid_early", int'(press_valid), 0);
        tick();
        check("bounce_valid_edge7", int'(press_valid), 1);
        repeat (8) tick();
        btn = 3'b000;
        repeat (12) tick();
        check("bounce_xfers", n_xfer - x0, 1);
        check("bounce_pending", exp_q.size(), 0);
        exp_q.delete();

        // Release glitch during release debounce
        x0 = n_xfer;
        exp_q.push_back(2'd0);
        btn = 3'b001;
        repeat (10) tick();
        btn = 3'b000;
        tick(); tick();
        btn = 3'b100;
        tick();
        btn = 3'b000;
        repeat (4) tick();
        check("glitch_busy_r6", int'(busy), 1);
        repeat (2) tick();
        check("glitch_busy_r8", int'(busy), 1);
        tick();
        check("glitch_busy_r9", int'(busy), 0);
        repeat (4) tick();
        check("glitch_xfers", n_xfer - x0, 1);
        check("glitch_multi", int'(multi_err), 0);
        exp_q.delete();

        // Asynchronous reset while a code waits for acceptance
        press_ready = 1'b0;
        btn = 3'b010;
        for (int k = 0; k < 20 && !press_valid; k++) tick();
        check("rstmid_reached_valid", int'(press_valid), 1);
        check("rstmid_code_before", int'(press_code), 1);
        #2;
        reset = 1'b1;
        btn   = 3'b000;
        #1;
        check("rstmid_valid", int'(press_valid), 0);
        check("rstmid_code",  int'(press_code),  0);
        check("rstmid_busy",  int'(busy),        0);
        check("rstmid_multi", int'(multi_err),   0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        x0 = n_xfer;
        exp_q.push_back(2'd0);
        press_ready = 1'b1;
        btn = 3'b001;
        repeat (10) tick();
        btn = 3'b000;
        repeat (12) tick();
        check("rstmid_new_xfer", n_xfer - x0, 1);
        check("rstmid_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
